// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: moves 1/2/4 bytes big-endian, one byte per cycle, to a byte-wide memory.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module mem_access_unit #(
  parameter int ADDR_W = 11,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [1:0]        reqSize,
  input  logic              reqUnsigned,
  input  logic [31:0]       reqAddr,
  input  logic [31:0]       reqWdata,
  input  logic [TAG_W-1:0]  reqTag,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWe,
  output logic [7:0]        memWdata,
  input  logic [7:0]        memRdata,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [31:0]       rspData,
  output logic [TAG_W-1:0]  rspTag,
  output logic              rspErr,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never drops and its payload never changes until that edge.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e             state_q;
  logic               write_q;
  logic               unsigned_q;
  logic [1:0]         size_q;
  logic [TAG_W-1:0]   tag_q;
  logic [31:0]        wdata_q;
  logic [ADDR_W-1:0]  base_q;
  logic [1:0]         idx_q;
  logic [1:0]         last_q;
  logic [31:0]        acc_q;
  logic [31:0]        rsp_data_q;
  logic               rsp_err_q;

  logic [ADDR_W-1:0]  req_base;
  logic [1:0]         req_last;
  logic               req_trap;
  logic [31:0]        acc_d;
  logic [31:0]        load_ext;
  logic [1:0]         byte_sel;
  logic               in_access;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^reqAddr[31:ADDR_W];

  always_comb begin
    req_base = reqAddr[ADDR_W-1:0];
    req_last = 2'd3;
    case (reqSize)
      2'b00: req_last = 2'd0;
      2'b01: begin
        req_last    = 2'd1;
        req_base[0] = 1'b0;
      end
      default: begin
        req_last      = 2'd3;
        req_base[1:0] = 2'b00;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    case (reqSize)
      2'b00:   req_trap = 1'b0;
      2'b01:   req_trap = reqAddr[0];
      default: req_trap = |reqAddr[1:0];
    endcase
  end
`else
  assign req_trap = 1'b0;
`endif

  // Loads shift in from the right, so the lowest address ends up most significant.
  assign acc_d = {acc_q[23:0], memRdata};

  always_comb begin
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'd0, acc_d[7:0]}  : {{24{acc_d[7]}}, acc_d[7:0]};
      2'b01:   load_ext = unsigned_q ? {16'd0, acc_d[15:0]} : {{16{acc_d[15]}}, acc_d[15:0]};
      default: load_ext = acc_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      tag_q      <= '0;
      wdata_q    <= 32'd0;
      base_q     <= '0;
      idx_q      <= 2'd0;
      last_q     <= 2'd0;
      acc_q      <= 32'd0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reqValid) begin
            write_q    <= reqWrite;
            unsigned_q <= reqUnsigned;
            size_q     <= reqSize;
            tag_q      <= reqTag;
            wdata_q    <= reqWdata;
            base_q     <= req_base;
            last_q     <= req_last;
            idx_q      <= 2'd0;
            acc_q      <= 32'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= req_trap;
            state_q    <= req_trap ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (!write_q) begin
            acc_q <= acc_d;
          end
          if (idx_q == last_q) begin
            rsp_data_q <= write_q ? 32'd0 : load_ext;
            state_q    <= RESP;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        RESP: begin
          if (rspReady) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_access = (state_q == ACCESS);
  // Byte N-1-idx of the store word: most significant byte goes out first.
  assign byte_sel  = last_q - idx_q;

  always_comb begin
    memWe    = 1'b0;
    memAddr  = '0;
    memWdata = 8'd0;
    if (in_access) begin
      memAddr = base_q + ADDR_W'(idx_q);
      if (write_q) begin
        memWe = 1'b1;
        case (byte_sel)
          2'd0:    memWdata = wdata_q[7:0];
          2'd1:    memWdata = wdata_q[15:8];
          2'd2:    memWdata = wdata_q[23:16];
          default: memWdata = wdata_q[31:24];
        endcase
      end
    end
  end

  assign reqReady  = (state_q == IDLE);
  assign rspValid  = (state_q == RESP);
  assign rspData   = rsp_data_q;
  assign rspTag    = tag_q;
  assign rspErr    = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural byte memory, reference model and response scoreboard.
module tb_mem_access_unit;

  localparam int ADDR_W = 11;
  localparam int TAG_W  = 5;
  localparam int W      = 32 + TAG_W + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              reqValid = 1'b0;
  logic              reqReady;
  logic              reqWrite = 1'b0;
  logic [1:0]        reqSize = 2'b00;
  logic              reqUnsigned = 1'b0;
  logic [31:0]       reqAddr = 32'd0;
  logic [31:0]       reqWdata = 32'd0;
  logic [TAG_W-1:0]  reqTag = '0;
  logic [ADDR_W-1:0] memAddr;
  logic              memWe;
  logic [7:0]        memWdata;
  logic [7:0]        memRdata;
  logic              rspValid;
  logic              rspReady = 1'b0;
  logic [31:0]       rspData;
  logic [TAG_W-1:0]  rspTag;
  logic              rspErr;
  logic [1:0]        dbg_state;

  logic [7:0] mem     [0:2047];
  logic [7:0] ref_mem [0:2047];
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;

  mem_access_unit #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqSize(reqSize),
    .reqUnsigned(reqUnsigned), .reqAddr(reqAddr), .reqWdata(reqWdata), .reqTag(reqTag),
    .memAddr(memAddr), .memWe(memWe), .memWdata(memWdata), .memRdata(memRdata),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspTag(rspTag),
    .rspErr(rspErr), .dbg_state(dbg_state)
  );

  // Clock / memory
  always #5 clk = ~clk;

  assign memRdata = mem[memAddr];

  always @(posedge clk) begin
    if (memWe) begin
      mem[memAddr] = memWdata;
      we_cnt = we_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: big-endian byte memory, updates ref_mem for stores.
  task automatic model(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] data, output logic err,
                       output logic [10:0] base, output int n);
    logic [31:0] tmp;
    n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = addr[10:0];
    if (n == 2) base[0] = 1'b0;
    if (n == 4) base[1:0] = 2'b00;
    err  = 1'b0;
    data = 32'd0;
`ifdef MISALIGN_TRAP_EN
    if ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00)) begin
      err = 1'b1;
      return;
    end
`endif
    if (w) begin
      for (int i = 0; i < n; i++) begin
        tmp = wd >> (8 * (n - 1 - i));
        ref_mem[int'(base) + i] = tmp[7:0];
      end
    end else begin
      for (int i = 0; i < n; i++) data = {data[23:0], ref_mem[int'(base) + i]};
      if (n == 1) data = uns ? (data & 32'h0000_00FF) : 32'($signed(data[7:0]));
      if (n == 2) data = uns ? (data & 32'h0000_FFFF) : 32'($signed(data[15:0]));
    end
  endtask

  // Driver + response collector for one request with `stall` cycles of back-pressure.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [TAG_W-1:0] tag, input int stall);
    logic [31:0] d;
    logic        e;
    logic [10:0] base;
    int          n, lat, we0;
    logic [W-1:0] exp;
    model(w, sz, uns, addr, wd, d, e, base, n);
    exp_q.push_back({d, tag, e});
    @(negedge clk);
    lat = 0;
    while (!reqReady && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("req_ready", 32'(reqReady), 32'd1);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqUnsigned = uns;
    reqAddr = addr; reqWdata = wd; reqTag = tag;
    we0 = we_cnt;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    lat = 1;
    while (!rspValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", 32'(lat), e ? 32'd1 : 32'(n + 1));
    exp = exp_q[0];
    for (int s = 0; s < stall; s++) begin
      check("bp_valid", 32'(rspValid), 32'd1);
      check("bp_data", rspData, exp[W-1:TAG_W+1]);
      check("bp_tag", 32'(rspTag), 32'(exp[TAG_W:1]));
      check("bp_req_ready", 32'(reqReady), 32'd0);
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    check("rsp_data", rspData, exp[W-1:TAG_W+1]);
    check("rsp_tag", 32'(rspTag), 32'(exp[TAG_W:1]));
    check("rsp_err", 32'(rspErr), 32'(exp[0]));
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    check("idle_after_rsp", 32'(reqReady), 32'd1);
    check("we_pulses", 32'(we_cnt - we0), (w && !e) ? 32'(n) : 32'd0);
    if (w && !e)
      for (int i = 0; i < n; i++)
        check("mem_byte", 32'(mem[int'(base) + i]), 32'(ref_mem[int'(base) + i]));
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    mem[11'h020] = 8'h80; ref_mem[11'h020] = 8'h80;
    mem[11'h021] = 8'hF0; ref_mem[11'h021] = 8'hF0;

    // Asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(reqReady), 32'd1);
    check("rst_rsp_valid", 32'(rspValid), 32'd0);
    check("rst_rsp_data", rspData, 32'd0);
    check("rst_rsp_tag", 32'(rspTag), 32'd0);
    check("rst_rsp_err", 32'(rspErr), 32'd0);
    check("rst_mem_we", 32'(memWe), 32'd0);
    check("rst_mem_addr", 32'(memAddr), 32'd0);
    check("rst_mem_wdata", 32'(memWdata), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Word store then load
    run_req(1'b1, 2'b10, 1'b0, 32'h010, 32'h1122_3344, 5'd1, 0);
    check("sw_bytes", {mem[11'h010], mem[11'h011], mem[11'h012], mem[11'h013]}, 32'h1122_3344);
    run_req(1'b0, 2'b10, 1'b0, 32'h010, 32'd0, 5'd2, 0);

    // Sign / zero extension
    run_req(1'b0, 2'b00, 1'b0, 32'h020, 32'd0, 5'd3, 0);
    run_req(1'b0, 2'b00, 1'b1, 32'h020, 32'd0, 5'd4, 0);
    run_req(1'b0, 2'b01, 1'b0, 32'h020, 32'd0, 5'd5, 0);
    run_req(1'b0, 2'b01, 1'b1, 32'h020, 32'd0, 5'd6, 1);

    // Back-pressure, then a back-to-back request
    run_req(1'b0, 2'b10, 1'b0, 32'h010, 32'd0, 5'd7, 6);
    run_req(1'b0, 2'b00, 1'b1, 32'h011, 32'd0, 5'd8, 0);

    // Misaligned word; size 11 behaves as word
    run_req(1'b0, 2'b10, 1'b0, 32'h013, 32'd0, 5'd9, 0);
    run_req(1'b0, 2'b11, 1'b1, 32'h010, 32'd0, 5'd10, 0);

    // Address truncation
    run_req(1'b1, 2'b00, 1'b0, 32'hFFFF_F805, 32'h0000_00AB, 5'd11, 0);
    check("trunc_byte5", 32'(mem[5]), 32'h0000_00AB);
    check("trunc_byte4", 32'(mem[4]), 32'(8'h04 ^ 8'h5A));
    check("trunc_byte6", 32'(mem[6]), 32'(8'h06 ^ 8'h5A));

    // Random mix
    for (int k = 0; k < 24; k++) begin
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 32'hFFFF)), $urandom, 5'($urandom_range(0, 31)),
              $urandom_range(0, 3));
    end

    // Reset in the middle of a word store, after two bytes
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b10; reqUnsigned = 1'b0;
    reqAddr = 32'h030; reqWdata = 32'hDEAD_BEEF; reqTag = 5'd12;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(reqReady), 32'd1);
    check("midrst_rsp_valid", 32'(rspValid), 32'd0);
    check("midrst_mem_we", 32'(memWe), 32'd0);
    check("midrst_byte0", 32'(mem[11'h030]), 32'h0000_00DE);
    check("midrst_byte1", 32'(mem[11'h031]), 32'h0000_00AD);
    check("midrst_byte2", 32'(mem[11'h032]), 32'(ref_mem[11'h032]));
    check("midrst_byte3", 32'(mem[11'h033]), 32'(ref_mem[11'h033]));
    ref_mem[11'h030] = 8'hDE;
    ref_mem[11'h031] = 8'hAD;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", 32'(rspValid), 32'd0);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h030, 32'd0, 5'd13, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
